// File: rtl/decl_emit.sv
// Streams a C-style declaration "int <p>0, <p>1, ...;" one byte per handshake.
// Every output is registered; each state names the byte that is currently on out.
module decl_emit #(
    parameter logic [7:0]  SEP_CHAR = 8'h20,
    parameter int unsigned MAX_IDS  = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] n_ids,
    input  logic [1:0] gap,
    input  logic [7:0] prefix,
    output logic [7:0] out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [3:0] {
        IDLE,
        KW_I,
        KW_N,
        KW_T,
        SEP,
        ID_HEAD,
        ID_DIG,
        COMMA,
        GAP,
        SEMI,
        FIN
    } state_t;

    localparam logic [2:0] MAX_IDS_L = 3'(MAX_IDS);

    state_t     state_q, state_d;
    logic [7:0] out_q, out_d;
    logic       out_valid_q, out_valid_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic [2:0] k_q, k_d;
    logic [1:0] gap_cnt_q, gap_cnt_d;
    logic [2:0] n_ids_q, n_ids_d;
    logic [1:0] gap_q, gap_d;
    logic [7:0] prefix_q, prefix_d;

    logic handshake;
    logic count_ok;
    logic prefix_ok;
    logic start_ok;
    logic last_id;
    logic [7:0] next_digit;

    assign handshake  = out_valid_q && out_ready;
    assign count_ok   = (n_ids != 3'd0) && (n_ids <= MAX_IDS_L);
    assign prefix_ok  = ((prefix >= 8'h61) && (prefix <= 8'h7a)) ||
                        ((prefix >= 8'h41) && (prefix <= 8'h5a)) ||
                        (prefix == 8'h5f);
    assign start_ok   = count_ok && prefix_ok;
    assign last_id    = (k_q == (n_ids_q - 3'd1));
    assign next_digit = 8'h30 + {5'd0, k_q};

    // Next byte is loaded into out_d on the same edge that retires the current one,
    // which keeps out_valid high back-to-back when the sink never stalls.
    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        k_d         = k_q;
        gap_cnt_d   = gap_cnt_q;
        n_ids_d     = n_ids_q;
        gap_d       = gap_q;
        prefix_d    = prefix_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (start_ok) begin
                        state_d     = KW_I;
                        out_d       = 8'h69;
                        out_valid_d = 1'b1;
                        busy_d      = 1'b1;
                        k_d         = 3'd0;
                        gap_cnt_d   = 2'd0;
                        n_ids_d     = n_ids;
                        gap_d       = gap;
                        prefix_d    = prefix;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            KW_I: begin
                if (handshake) begin
                    state_d = KW_N;
                    out_d   = 8'h6e;
                end
            end
            KW_N: begin
                if (handshake) begin
                    state_d = KW_T;
                    out_d   = 8'h74;
                end
            end
            KW_T: begin
                if (handshake) begin
                    state_d = SEP;
                    out_d   = SEP_CHAR;
                end
            end
            SEP: begin
                if (handshake) begin
                    state_d = ID_HEAD;
                    out_d   = prefix_q;
                end
            end
            ID_HEAD: begin
                if (handshake) begin
                    state_d = ID_DIG;
                    out_d   = next_digit;
                end
            end
            ID_DIG: begin
                if (handshake) begin
                    if (last_id) begin
                        state_d = SEMI;
                        out_d   = 8'h3b;
                    end else begin
                        state_d = COMMA;
                        out_d   = 8'h2c;
                    end
                end
            end
            COMMA: begin
                if (handshake) begin
                    if (gap_q != 2'd0) begin
                        state_d   = GAP;
                        out_d     = SEP_CHAR;
                        gap_cnt_d = gap_q;
                    end else begin
                        state_d = ID_HEAD;
                        out_d   = prefix_q;
                        k_d     = k_q + 3'd1;
                    end
                end
            end
            // gap_cnt_q counts the separator bytes still owed, including the one on out.
            GAP: begin
                if (handshake) begin
                    if (gap_cnt_q == 2'd1) begin
                        state_d   = ID_HEAD;
                        out_d     = prefix_q;
                        k_d       = k_q + 3'd1;
                        gap_cnt_d = 2'd0;
                    end else begin
                        gap_cnt_d = gap_cnt_q - 2'd1;
                    end
                end
            end
            SEMI: begin
                if (handshake) begin
                    state_d     = FIN;
                    out_d       = 8'h00;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d     = IDLE;
                out_d       = 8'h00;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            out_q       <= 8'h00;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            k_q         <= 3'd0;
            gap_cnt_q   <= 2'd0;
            n_ids_q     <= 3'd0;
            gap_q       <= 2'd0;
            prefix_q    <= 8'h00;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            k_q         <= k_d;
            gap_cnt_q   <= gap_cnt_d;
            n_ids_q     <= n_ids_d;
            gap_q       <= gap_d;
            prefix_q    <= prefix_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_decl_emit.sv
// Directed bench for decl_emit: table of declarations with expected text,
// plus hand-written reset-abort and restart sequences.
module tb_decl_emit;

    logic       clk;
    logic       reset;
    logic       start;
    logic [2:0] n_ids;
    logic [1:0] gap;
    logic [7:0] prefix;
    logic [7:0] out;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       done;
    logic       err;

    int checks;
    int errors;

    typedef struct packed {
        logic [2:0]      n_ids;
        logic [1:0]      gap;
        logic [7:0]      prefix;
        logic            ready_mode;
        logic            poke;
        logic            expect_err;
        logic [7:0]      len;
        logic [8*40-1:0] exp;
    } vec_t;

    localparam int NUM_VECS = 15;
    vec_t vecs [NUM_VECS];

    decl_emit #(
        .SEP_CHAR(8'h20),
        .MAX_IDS (7)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .n_ids    (n_ids),
        .gap      (gap),
        .prefix   (prefix),
        .out      (out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic [2:0] n, input logic [1:0] g,
                                input logic [7:0] p, input logic rm,
                                input logic pk, input logic ee,
                                input logic [7:0] ln, input logic [8*40-1:0] e);
        vec_t v;
        v.n_ids      = n;
        v.gap        = g;
        v.prefix     = p;
        v.ready_mode = rm;
        v.poke       = pk;
        v.expect_err = ee;
        v.len        = ln;
        v.exp        = e;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Called at the falling edge where 'i' is already presented.
    task automatic runStream(input int len, input logic [8*40-1:0] exp,
                             input logic mode, input logic poke);
        int         got;
        int         cyc;
        logic       stalled;
        logic [7:0] held;
        logic [7:0] want;
        got     = 0;
        cyc     = 0;
        stalled = 1'b0;
        held    = 8'h00;
        while (got < len && cyc < 400) begin
            out_ready = mode ? ((cyc % 3) == 0) : 1'b1;
            if (poke && got >= 1 && (got + 3) < len) begin
                start  = 1'b1;
                n_ids  = 3'd5;
                gap    = 2'd3;
                prefix = "z";
            end else begin
                start = 1'b0;
            end
            checkOutput("valid_held", {31'd0, out_valid}, 32'd1);
            checkOutput("busy_held", {31'd0, busy}, 32'd1);
            checkOutput("no_early_done", {31'd0, done}, 32'd0);
            if (stalled) checkOutput("stall_stable", {24'd0, out}, {24'd0, held});
            if (out_ready) begin
                want = exp[8*(len-1-got) +: 8];
                checkOutput($sformatf("byte%0d", got), {24'd0, out}, {24'd0, want});
                got++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                held    = out;
            end
            @(negedge clk);
            cyc++;
        end
        start     = 1'b0;
        out_ready = 1'b1;
        checkOutput("stream_len", got, len);
        checkOutput("fin_done", {31'd0, done}, 32'd1);
        checkOutput("fin_busy", {31'd0, busy}, 32'd0);
        checkOutput("fin_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        checkOutput("done_once", {31'd0, done}, 32'd0);
        checkOutput("idle_valid", {31'd0, out_valid}, 32'd0);
    endtask

    // Drives start at the current falling edge; fields are scrambled after acceptance.
    task automatic applyStimulus(input vec_t v);
        start     = 1'b1;
        n_ids     = v.n_ids;
        gap       = v.gap;
        prefix    = v.prefix;
        out_ready = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        n_ids  = 3'd0;
        gap    = 2'd0;
        prefix = 8'h00;
        if (v.expect_err) begin
            checkOutput("err_pulse", {31'd0, err}, 32'd1);
            checkOutput("err_busy", {31'd0, busy}, 32'd0);
            checkOutput("err_valid", {31'd0, out_valid}, 32'd0);
            @(negedge clk);
            checkOutput("err_clear", {31'd0, err}, 32'd0);
            checkOutput("err_valid2", {31'd0, out_valid}, 32'd0);
            checkOutput("err_busy2", {31'd0, busy}, 32'd0);
        end else begin
            checkOutput("first_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("first_busy", {31'd0, busy}, 32'd1);
            checkOutput("no_err", {31'd0, err}, 32'd0);
            runStream(int'(v.len), v.exp, v.ready_mode, v.poke);
        end
    endtask

    initial begin
        logic [39:0] s5;
        checks    = 0;
        errors    = 0;
        reset     = 1'b0;
        start     = 1'b0;
        n_ids     = 3'd0;
        gap       = 2'd0;
        prefix    = 8'h00;
        out_ready = 1'b0;

        vecs[0]  = mk(3'd2, 2'd1, "x", 1'b0, 1'b0, 1'b0, 8'd11, "int x0, x1;");
        vecs[1]  = mk(3'd1, 2'd3, "_", 1'b0, 1'b0, 1'b0, 8'd7,  "int _0;");
        vecs[2]  = mk(3'd3, 2'd0, "a", 1'b1, 1'b0, 1'b0, 8'd13, "int a0,a1,a2;");
        vecs[3]  = mk(3'd1, 2'd0, "5", 1'b0, 1'b0, 1'b1, 8'd0,  "");
        vecs[4]  = mk(3'd0, 2'd0, "a", 1'b0, 1'b0, 1'b1, 8'd0,  "");
        vecs[5]  = mk(3'd1, 2'd0, "i", 1'b0, 1'b0, 1'b0, 8'd7,  "int i0;");
        vecs[6]  = mk(3'd7, 2'd2, "Z", 1'b1, 1'b0, 1'b0, 8'd37, "int Z0,  Z1,  Z2,  Z3,  Z4,  Z5,  Z6;");
        vecs[7]  = mk(3'd2, 2'd3, "b", 1'b0, 1'b0, 1'b0, 8'd13, "int b0,   b1;");
        vecs[8]  = mk(3'd2, 2'd1, "x", 1'b0, 1'b1, 1'b0, 8'd11, "int x0, x1;");
        vecs[9]  = mk(3'd2, 2'd0, "@", 1'b0, 1'b0, 1'b1, 8'd0,  "");
        vecs[10] = mk(3'd2, 2'd0, "[", 1'b0, 1'b0, 1'b1, 8'd0,  "");
        vecs[11] = mk(3'd2, 2'd0, 8'h60, 1'b0, 1'b0, 1'b1, 8'd0,  "");
        vecs[12] = mk(3'd2, 2'd0, "{", 1'b0, 1'b0, 1'b1, 8'd0,  "");
        vecs[13] = mk(3'd1, 2'd0, "A", 1'b0, 1'b0, 1'b0, 8'd7,  "int A0;");
        vecs[14] = mk(3'd1, 2'd2, "z", 1'b1, 1'b0, 1'b0, 8'd7,  "int z0;");

        repeat (3) @(negedge clk);
        checkOutput("rst_out", {24'd0, out}, 32'd0);
        checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_err", {31'd0, err}, 32'd0);

        // Start is driven in the same cycle reset is released.
        reset = 1'b1;
        for (int i = 0; i < NUM_VECS; i++) begin
            $display("[TB] vector %0d", i);
            applyStimulus(vecs[i]);
        end

        $display("[TB] reset mid-declaration");
        s5        = "int a";
        start     = 1'b1;
        n_ids     = 3'd3;
        gap       = 2'd0;
        prefix    = "a";
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int j = 0; j < 5; j++) begin
            checkOutput($sformatf("abort_byte%0d", j), {24'd0, out}, {24'd0, s5[8*(4-j) +: 8]});
            @(negedge clk);
        end
        checkOutput("abort_next", {24'd0, out}, 32'h30);
        #2 reset = 1'b0;
        #1;
        checkOutput("abort_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("abort_out", {24'd0, out}, 32'd0);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        checkOutput("abort_no_done", {31'd0, done}, 32'd0);
        checkOutput("abort_valid2", {31'd0, out_valid}, 32'd0);
        reset = 1'b1;
        applyStimulus(mk(3'd1, 2'd0, "q", 1'b0, 1'b0, 1'b0, 8'd7, "int q0;"));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
